match_result_ctrl: RTL
======================

MATCH_RESULT_CTRL -- requirements
Module: match_result_ctrl

Interface
REQ-001 Parameters SHALL be: SEGWID, default 10, comparator result width; IDWID, default 8, rule ID width; TAGWID, default 8, search tag width; CMP_LAT, default 5, comparator pipeline latency in cycles; FDEP, default 8, result FIFO depth.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 i_Search_Valid  input  1  high in the cycle a mask vector is presented to the comparator tree.
REQ-005 i_Search_Tag  input  TAGWID  tag of that search, sampled with i_Search_Valid.
REQ-006 o_Search_Ready  output  1  upstream may assert i_Search_Valid only while this is high.
REQ-007 i_Compare_Result  input  SEGWID  comparator tree output, CMP_LAT cycles after the vector.
REQ-008 o_Res_Valid / i_Res_Ready  output/input  1 each  result handshake; transfer when both high.
REQ-009 o_Res_Hit  output  1  result bit [9] (match flag).
REQ-010 o_Res_Flag  output  1  result bit [8] (status flag, passed through).
REQ-011 o_Res_ID  output  IDWID  result bits [7:0], rule ID.
REQ-012 o_Res_Tag  output  TAGWID  tag of the search that produced the result.
REQ-013 o_Hit_Cnt / o_Miss_Cnt  output  16 each  saturating result counters.
REQ-014 o_Overflow  output  1  sticky error flag.

Function
REQ-015 A valid/tag delay line of exactly CMP_LAT stages SHALL align each search with its i_Compare_Result; a search accepted at cycle N SHALL be captured at the edge ending cycle N+CMP_LAT.
REQ-016 The delay line SHALL shift every cycle without stalling; the comparator cannot be back-pressured.
REQ-017 Captured entries {hit, flag, id, tag} SHALL be pushed into a FIFO of depth FDEP.
REQ-018 inflight = number of set valid bits in the delay line; o_Search_Ready SHALL equal (fifo_count + inflight) < FDEP, evaluated combinationally from registered state.
REQ-019 o_Res_Valid SHALL equal FIFO non-empty; output fields SHALL show the FIFO head (show-ahead); the head SHALL hold stable while o_Res_Valid=1 and i_Res_Ready=0.
REQ-020 A push and a pop in the same cycle SHALL leave the count unchanged, including when full or empty (an empty FIFO with simultaneous push SHALL NOT pop).
REQ-021 Read/write pointers SHALL wrap modulo FDEP; count range is 0..FDEP.
REQ-022 On each push, o_Hit_Cnt SHALL increment if hit=1, otherwise o_Miss_Cnt SHALL increment; both saturate at 16'hFFFF.
REQ-023 A push when the FIFO is full and not popping SHALL drop the entry and set o_Overflow; o_Overflow clears only on reset.
REQ-024 i_Search_Valid while o_Search_Ready=0 SHALL still be tracked; any resulting overflow is signalled by REQ-023.

Reset
REQ-025 On rst_n low, asynchronously: delay line valid bits 0, FIFO empty, pointers 0, counters 0, o_Overflow 0, o_Res_Valid 0, o_Search_Ready 1.
REQ-026 A reset mid-operation SHALL discard all in-flight and queued results; the first search after release SHALL behave as REQ-015.
REQ-027 Data/tag storage need not be reset; outputs are don't-care while o_Res_Valid=0.

Structure
REQ-028 SEGWID, IDWID, TAGWID, CMP_LAT, FDEP and the result bit positions (HIT_BIT=9, FLAG_BIT=8, ID_LSB=0) SHALL reside in the shared TCAM package.
REQ-029 The FIFO SHALL be a sub-module named result_fifo (parameterised width/depth, count output); the delay line and counters stay in the top module.

Verification
REQ-030 Single search tag 8'h3C at cycle 0, result 10'h2A5 at cycle 5, i_Res_Ready=1 -> o_Res_Valid at cycle 6, Hit=1, Flag=0, ID=8'hA5, Tag=8'h3C; o_Hit_Cnt=1.
REQ-031 Back-to-back 8 searches, i_Res_Ready=0 -> o_Search_Ready drops after the 8th acceptance, FIFO fills to 8, no overflow; releasing ready drains in order with tags 0..7.
REQ-032 Ignore o_Search_Ready and issue a 9th search while full with ready low -> o_Overflow=1, first 8 entries intact.
REQ-033 Full FIFO, simultaneous push and pop -> count stays 8, head advances, no overflow.
REQ-034 Preload o_Miss_Cnt to 16'hFFFF via 65535 misses, one more miss -> stays 16'hFFFF.
REQ-035 rst_n low for one cycle with 3 in flight and 4 queued -> o_Res_Valid=0, counters 0; new search after release returns in 5+1 cycles.

Source files
------------

// File: rtl/match_result_ctrl_pkg.sv
// Shared TCAM parameters, result bit positions and helpers.
// Imported by match_result_ctrl and result_fifo.
package match_result_ctrl_pkg;

    localparam int SEGWID   = 10;
    localparam int IDWID    = 8;
    localparam int TAGWID   = 8;
    localparam int CMP_LAT  = 5;
    localparam int FDEP     = 8;

    localparam int HIT_BIT  = 9;
    localparam int FLAG_BIT = 8;
    localparam int ID_LSB   = 0;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/match_result_ctrl_result_fifo.sv
// Show-ahead result FIFO with occupancy count.
// Ports: clk, rst_n, push/wdata, pop/rdata, count, full, empty.
module result_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          wr;
    logic          rd;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // A full FIFO may still accept a write when the head leaves this cycle.
    assign wr    = push & (~full | pop);
    assign rd    = pop & ~empty;
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= nxt(wptr);
            if (rd) rptr <= nxt(rptr);
            if (wr && !rd)      count <= count + CW'(1);
            else if (rd && !wr) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/match_result_ctrl.sv
// Aligns searches with comparator results, queues them and counts hits.
// Ports: search in/ready, compare result, result handshake + fields, counters, overflow.
module match_result_ctrl #(
    parameter int SEGWID  = match_result_ctrl_pkg::SEGWID,
    parameter int IDWID   = match_result_ctrl_pkg::IDWID,
    parameter int TAGWID  = match_result_ctrl_pkg::TAGWID,
    parameter int CMP_LAT = match_result_ctrl_pkg::CMP_LAT,
    parameter int FDEP    = match_result_ctrl_pkg::FDEP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_Search_Valid,
    input  logic [TAGWID-1:0] i_Search_Tag,
    output logic              o_Search_Ready,
    input  logic [SEGWID-1:0] i_Compare_Result,
    output logic              o_Res_Valid,
    input  logic              i_Res_Ready,
    output logic              o_Res_Hit,
    output logic              o_Res_Flag,
    output logic [IDWID-1:0]  o_Res_ID,
    output logic [TAGWID-1:0] o_Res_Tag,
    output logic [15:0]       o_Hit_Cnt,
    output logic [15:0]       o_Miss_Cnt,
    output logic              o_Overflow
);
    import match_result_ctrl_pkg::*;

    localparam int EW = 2 + IDWID + TAGWID;
    localparam int CW = $clog2(FDEP + 1);
    localparam int LW = $clog2(CMP_LAT + 1);

    logic [CMP_LAT-1:0] dl_vld;
    logic [TAGWID-1:0]  dl_tag [CMP_LAT];
    logic [LW-1:0]      inflight;
    logic [CW-1:0]      fifo_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               cap_hit;
    logic [EW-1:0]      wdata;
    logic [EW-1:0]      rdata;

    // Free-running alignment pipe; it never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_vld <= '0;
        end else begin
            dl_vld[0] <= i_Search_Valid;
            for (int i = 1; i < CMP_LAT; i++) dl_vld[i] <= dl_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        dl_tag[0] <= i_Search_Tag;
        for (int i = 1; i < CMP_LAT; i++) dl_tag[i] <= dl_tag[i-1];
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < CMP_LAT; i++) inflight = inflight + LW'(dl_vld[i]);
    end

    // Reserve a FIFO slot for every search still in the pipe.
    assign o_Search_Ready = (int'(fifo_cnt) + int'(inflight)) < FDEP;

    assign push    = dl_vld[CMP_LAT-1];
    assign pop     = o_Res_Valid & i_Res_Ready;
    assign cap_hit = i_Compare_Result[HIT_BIT];
    assign wdata   = {cap_hit,
                      i_Compare_Result[FLAG_BIT],
                      i_Compare_Result[ID_LSB +: IDWID],
                      dl_tag[CMP_LAT-1]};

    result_fifo #(
        .W     (EW),
        .DEPTH (FDEP)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign o_Res_Valid = ~fifo_empty;
    assign {o_Res_Hit, o_Res_Flag, o_Res_ID, o_Res_Tag} = rdata;

    // Every captured result is counted, including one that is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_Hit_Cnt  <= '0;
            o_Miss_Cnt <= '0;
            o_Overflow <= 1'b0;
        end else if (push) begin
            if (cap_hit) o_Hit_Cnt  <= sat_inc(o_Hit_Cnt);
            else         o_Miss_Cnt <= sat_inc(o_Miss_Cnt);
            if (fifo_full && !pop) o_Overflow <= 1'b1;
        end
    end

endmodule
